// File: rtl/byte_pack_pkg.sv
// Shared types and width helpers for the byte packer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package byte_pack_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Width of a field that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/byte_pack_align.sv
// Shifts a byte vector by a variable number of whole bytes, either direction.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (NB bytes, MSB = byte 0), shift (bytes), left (1 = toward MSB),
//        res (shifted vector, vacated lanes zero).
module byte_pack_align
    import byte_pack_pkg::*;
#(
    parameter int NB = 16,
    parameter int SW = 5
) (
    input  logic [NB*BYTE_W-1:0] vec,
    input  logic [SW-1:0]        shift,
    input  logic                 left,
    output logic [NB*BYTE_W-1:0] res
);

    // Left shift drops leading (oldest) bytes; right shift opens room at the head
    // so a new fragment lands behind bytes already held.
    always_comb begin
        res = '0;
        if (left) begin
            res = vec << {shift, 3'b000};
        end else begin
            res = vec >> {shift, 3'b000};
        end
    end

endmodule

// File: rtl/byte_pack_fifo.sv
// Packs 0..IN_BYTES bytes per beat into OUT_BYTES words; flush emits a residual partial word.
// Latency: a word completed on edge t is presented with dout_valid after edge t+1.
// Backpressure: din_ready from registered level/state only; output reg holds while !dout_ready.
// Ports: din/din_cnt/din_valid/din_ready input beats (MSB = first byte), flush request,
//        dout/dout_keep/dout_last/dout_valid/dout_ready output words, level = bytes buffered.
// Optional: define BYTE_PACK_ERR_EN to add a sticky err output and drop illegal beats.
module byte_pack_fifo
    import byte_pack_pkg::*;
#(
    parameter int IN_BYTES    = 4,
    parameter int OUT_BYTES   = 4,
    parameter int DEPTH_BYTES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IN_BYTES*8-1:0]            din,
    input  logic [$clog2(IN_BYTES+1)-1:0]    din_cnt,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic                             flush,
    output logic [OUT_BYTES*8-1:0]           dout,
    output logic [$clog2(OUT_BYTES+1)-1:0]   dout_keep,
    output logic                             dout_last,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [$clog2(DEPTH_BYTES+1)-1:0] level
`ifdef BYTE_PACK_ERR_EN
    ,
    output logic                             err
`endif
);

    localparam int IW = IN_BYTES * BYTE_W;
    localparam int OW = OUT_BYTES * BYTE_W;
    localparam int DW = DEPTH_BYTES * BYTE_W;
    localparam int KW = cnt_w(OUT_BYTES);
    localparam int LW = cnt_w(DEPTH_BYTES);

    // Buffer is MSB-aligned: oldest byte in the top lane. Lanes at or beyond
    // level are always zero, so the head slice of a partial word is already padded.
    logic [DW-1:0] mem_q;
    logic [LW-1:0] level_q;
    state_t        state_q, state_d;
    logic          rdy_en_q;

    logic [OW-1:0] dout_q;
    logic [KW-1:0] keep_q;
    logic          last_q;
    logic          dout_valid_q;

    int            cnt_c, pop_n, wr_n, level_d;
    logic          din_ready_c, load_ok, full_pop, part_pop, pop_last, wr_en;
    logic [IW-1:0] din_m;
    logic [DW-1:0] din_ext, kept, ins, mem_d;

    always_comb begin
        cnt_c       = (int'(din_cnt) > IN_BYTES) ? IN_BYTES : int'(din_cnt);
        din_ready_c = rdy_en_q && (state_q == RUN) &&
                      (DEPTH_BYTES - int'(level_q) >= IN_BYTES);
        load_ok     = !dout_valid_q || dout_ready;
        full_pop    = load_ok && (int'(level_q) >= OUT_BYTES);
        part_pop    = load_ok && (state_q == FLUSH) && (level_q != '0) &&
                      (int'(level_q) < OUT_BYTES);
        pop_n       = full_pop ? OUT_BYTES : (part_pop ? int'(level_q) : 0);
        // The word that empties the buffer during FLUSH closes the flush.
        pop_last    = part_pop ||
                      (full_pop && (state_q == FLUSH) && (int'(level_q) == OUT_BYTES));
    end

`ifdef BYTE_PACK_ERR_EN
    logic cnt_bad, err_set, err_q;
    always_comb begin
        cnt_bad = din_valid && (int'(din_cnt) > IN_BYTES);
        err_set = cnt_bad || (din_valid && !din_ready_c && (din_cnt != '0));
        wr_en   = din_valid && din_ready_c && !cnt_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    always_comb begin
        wr_en = din_valid && din_ready_c;
    end
`endif

    // Keep only the valid leading bytes of the beat so the OR-merge below
    // cannot disturb the zero tail of the buffer.
    always_comb begin
        wr_n  = wr_en ? cnt_c : 0;
        din_m = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i < wr_n) begin
                din_m[IW-1-i*BYTE_W -: BYTE_W] = din[IW-1-i*BYTE_W -: BYTE_W];
            end
        end
        din_ext = {din_m, {(DW-IW){1'b0}}};
    end

    byte_pack_align #(.NB(DEPTH_BYTES), .SW(LW)) u_compact (
        .vec   (mem_q),
        .shift (LW'(pop_n)),
        .left  (1'b1),
        .res   (kept)
    );

    // New bytes go behind whatever survives this cycle's pop.
    byte_pack_align #(.NB(DEPTH_BYTES), .SW(LW)) u_insert (
        .vec   (din_ext),
        .shift (LW'(int'(level_q) - pop_n)),
        .left  (1'b0),
        .res   (ins)
    );

    always_comb begin
        mem_d   = kept | ins;
        level_d = int'(level_q) - pop_n + wr_n;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((level_q == '0) || pop_last) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '0;
            level_q      <= '0;
            state_q      <= RUN;
            rdy_en_q     <= 1'b0;
            dout_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            level_q  <= LW'(level_d);
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (load_ok) begin
                dout_valid_q <= (pop_n != 0);
                if (pop_n != 0) begin
                    dout_q <= mem_q[DW-1 -: OW];
                    keep_q <= KW'(pop_n);
                    last_q <= pop_last;
                end
            end
        end
    end

    assign din_ready  = din_ready_c;
    assign dout       = dout_q;
    assign dout_keep  = keep_q;
    assign dout_last  = last_q;
    assign dout_valid = dout_valid_q;
    assign level      = level_q;

endmodule
